// File: rtl/rat_mul_sched.sv
// Round-robin scheduler for two requesters sharing one rational
// mul/div datapath; tagged result with zero-den flag, valid/ready.
//
// Ports:
//  clk, rst_n                       clock, async active-low reset
//  req_valid/req_ready [1:0]        per-requester handshake
//  req_div [1:0]                    1 = l/r, 0 = l*r
//  req_{l,r}_{num,den} [2*WIDTH]    slice i = [i*WIDTH +: WIDTH]
//  res_valid/res_ready              result handshake
//  res_tag, res_num, res_den        issuing requester and result
//  res_err                          result denominator is zero
module rat_mul_sched #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         req_valid,
  output logic [1:0]         req_ready,
  input  logic [1:0]         req_div,
  input  logic [2*WIDTH-1:0] req_l_num,
  input  logic [2*WIDTH-1:0] req_l_den,
  input  logic [2*WIDTH-1:0] req_r_num,
  input  logic [2*WIDTH-1:0] req_r_den,
  output logic               res_valid,
  input  logic               res_ready,
  output logic               res_tag,
  output logic [WIDTH-1:0]   res_num,
  output logic [WIDTH-1:0]   res_den,
  output logic               res_err
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    DONE
  } state_t;

  typedef struct packed {
    logic             div;
    logic [WIDTH-1:0] l_num;
    logic [WIDTH-1:0] l_den;
    logic [WIDTH-1:0] r_num;
    logic [WIDTH-1:0] r_den;
  } op_t;

  state_t state_q, state_d;
  op_t    op_q, op_d;
  logic   tag_q, tag_d;
  logic   last_q, last_d;

  logic [WIDTH-1:0] s_num_q;
  logic [WIDTH-1:0] s_den_q;

  logic [1:0] gnt;
  logic       gnt_idx;
  logic       win;
  logic       acc;

  // Requester != last grant wins a tie.
  always_comb begin
    gnt = 2'b00;
    unique case (1'b1)
      (req_valid == 2'b11): gnt = last_q ? 2'b01 : 2'b10;
      (req_valid == 2'b01): gnt = 2'b01;
      (req_valid == 2'b10): gnt = 2'b10;
      default:              gnt = 2'b00;
    endcase
  end

  assign gnt_idx = gnt[1];

  // Gated by rst_n so req_ready reads 0 while reset is held.
  assign win = rst_n
             & ((state_q == IDLE)
             | ((state_q == DONE) & res_ready));

  assign req_ready = win ? gnt : 2'b00;
  assign acc       = |req_ready;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    tag_d   = tag_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: if (acc) state_d = EXEC;
      EXEC: state_d = DONE;
      DONE: begin
        if (acc)            state_d = EXEC;
        else if (res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (acc) begin
      tag_d  = gnt_idx;
      last_d = gnt_idx;
      if (gnt_idx) begin
        op_d.div   = req_div[1];
        op_d.l_num = req_l_num[2*WIDTH-1:WIDTH];
        op_d.l_den = req_l_den[2*WIDTH-1:WIDTH];
        op_d.r_num = req_r_num[2*WIDTH-1:WIDTH];
        op_d.r_den = req_r_den[2*WIDTH-1:WIDTH];
      end else begin
        op_d.div   = req_div[0];
        op_d.l_num = req_l_num[WIDTH-1:0];
        op_d.l_den = req_l_den[WIDTH-1:0];
        op_d.r_num = req_r_num[WIDTH-1:0];
        op_d.r_den = req_r_den[WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= '0;
      tag_q   <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      tag_q   <= tag_d;
      last_q  <= last_d;
    end
  end

  // Shared mul datapath: one-cycle, unreset, truncating.
  // Division cross-multiplies: (ln/ld)/(rn/rd) = ln*rd / ld*rn.
  always_ff @(posedge clk) begin
    if (state_q == EXEC) begin
      s_num_q <= op_q.l_num
               * (op_q.div ? op_q.r_den : op_q.r_num);
      s_den_q <= op_q.l_den
               * (op_q.div ? op_q.r_num : op_q.r_den);
    end
  end

  assign res_valid = (state_q == DONE);
  assign res_tag   = tag_q;
  assign res_num   = s_num_q;
  assign res_den   = s_den_q;
  assign res_err   = res_valid & (s_den_q == '0);

endmodule

// File: tb/tb_rat_mul_sched.sv
// Bench for rat_mul_sched: vector table, scoreboard on the
// result port, plus backpressure/round-robin/reset sequences.
module tb_rat_mul_sched;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [1:0]  req_div;
  logic [63:0] req_l_num, req_l_den, req_r_num, req_r_den;
  logic        res_valid, res_ready, res_tag, res_err;
  logic [31:0] res_num, res_den;

  logic [1:0]  v8_valid, v8_ready, v8_div;
  logic [15:0] v8_l_num, v8_l_den, v8_r_num, v8_r_den;
  logic        r8_valid, r8_ready, r8_tag, r8_err;
  logic [7:0]  r8_num, r8_den;

  rat_mul_sched #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_div(req_div),
    .req_l_num(req_l_num), .req_l_den(req_l_den),
    .req_r_num(req_r_num), .req_r_den(req_r_den),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_tag(res_tag), .res_num(res_num),
    .res_den(res_den), .res_err(res_err)
  );

  rat_mul_sched #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(v8_valid), .req_ready(v8_ready),
    .req_div(v8_div),
    .req_l_num(v8_l_num), .req_l_den(v8_l_den),
    .req_r_num(v8_r_num), .req_r_den(v8_r_den),
    .res_valid(r8_valid), .res_ready(r8_ready),
    .res_tag(r8_tag), .res_num(r8_num),
    .res_den(r8_den), .res_err(r8_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        tag;
    logic [31:0] num;
    logic [31:0] den;
    logic        err;
  } exp_t;

  typedef struct {
    int          idx;
    bit          div;
    logic [31:0] ln, ld, rn, rd;
    logic [31:0] en, ed;
    bit          err;
  } vec_t;

  exp_t sb[$];
  vec_t vt[6];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] want);
    n_vec++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h at %0t",
               nm, act, want, $time);
    end
  endtask

  task automatic push(input logic t, input logic [31:0] n,
                      input logic [31:0] d, input logic e);
    exp_t x;
    x.tag = t; x.num = n; x.den = d; x.err = e;
    sb.push_back(x);
  endtask

  task automatic set_req(input int i, input bit d,
                         input logic [31:0] ln,
                         input logic [31:0] ld,
                         input logic [31:0] rn,
                         input logic [31:0] rd);
    req_div[i]            = d;
    req_l_num[i*32 +: 32] = ln;
    req_l_den[i*32 +: 32] = ld;
    req_r_num[i*32 +: 32] = rn;
    req_r_den[i*32 +: 32] = rd;
  endtask

  // Result scoreboard: pop on every result handshake.
  always @(negedge clk) begin
    if (rst_n && res_valid && res_ready) begin
      if (sb.size() == 0) begin
        chk("unexp_res", 32'(res_valid), 32'(0));
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("res_tag", 32'(res_tag), 32'(e.tag));
        chk("res_num", res_num, e.num);
        chk("res_den", res_den, e.den);
        chk("res_err", 32'(res_err), 32'(e.err));
      end
    end
  end

  task automatic drain();
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v);
    logic [1:0] oh;
    oh = (v.idx == 0) ? 2'b01 : 2'b10;
    @(posedge clk); #1;
    set_req(v.idx, v.div, v.ln, v.ld, v.rn, v.rd);
    req_valid = oh;
    res_ready = 1'b1;
    @(negedge clk);
    chk("vec_rdy", 32'(req_ready), 32'(oh));
    chk("vec_nv0", 32'(res_valid), 32'(0));
    push(v.idx[0], v.en, v.ed, v.err);
    @(posedge clk); #1;
    req_valid = 2'b00;
    @(negedge clk);
    chk("vec_exec", 32'(res_valid), 32'(0));
    @(negedge clk);
    chk("vec_lat", 32'(res_valid), 32'(1));
    drain();
  endtask

  initial begin
    vt[0] = '{0, 0, 3, 4, 5, 7, 15, 28, 0};
    vt[1] = '{1, 1, 3, 4, 5, 7, 21, 20, 0};
    vt[2] = '{0, 1, 1, 2, 0, 5, 5, 0, 1};
    vt[3] = '{1, 0, 1, 0, 2, 3, 2, 0, 1};
    vt[4] = '{0, 0, 32'h10000, 1, 32'h10000, 1, 0, 1, 0};
    vt[5] = '{1, 1, 7, 9, 11, 13, 91, 99, 0};

    rst_n     = 1'b0;
    req_valid = 2'b01;
    req_div   = '0;
    req_l_num = '0; req_l_den = '0;
    req_r_num = '0; req_r_den = '0;
    res_ready = 1'b1;
    v8_valid  = '0; v8_div = '0;
    v8_l_num  = '0; v8_l_den = '0;
    v8_r_num  = '0; v8_r_den = '0;
    r8_ready  = 1'b1;

    #12;
    chk("rst_rdy", 32'(req_ready), 32'(0));
    chk("rst_val", 32'(res_valid), 32'(0));
    chk("rst_tag", 32'(res_tag), 32'(0));
    chk("rst_err", 32'(res_err), 32'(0));
    req_valid = 2'b00;
    @(posedge clk); #1;
    rst_n = 1'b1;
    drain();

    for (int i = 0; i < 6; i++) run_vec(vt[i]);

    // Backpressure: result held, no accepts while stalled.
    @(posedge clk); #1;
    set_req(1, 1, 3, 4, 5, 7);
    req_valid = 2'b10;
    res_ready = 1'b0;
    @(negedge clk);
    chk("bp_rdy", 32'(req_ready), 32'(2'b10));
    push(1'b1, 21, 20, 1'b0);
    @(posedge clk); #1;
    set_req(0, 0, 1, 1, 1, 1);
    req_valid = 2'b01;
    @(negedge clk);
    chk("bp_exec_rdy", 32'(req_ready), 32'(0));
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("bp_val", 32'(res_valid), 32'(1));
      chk("bp_num", res_num, 21);
      chk("bp_den", res_den, 20);
      chk("bp_hold_rdy", 32'(req_ready), 32'(0));
    end
    @(posedge clk); #1;
    req_valid = 2'b00;
    res_ready = 1'b1;
    @(negedge clk);
    chk("bp_rel_rdy", 32'(req_ready), 32'(0));
    @(negedge clk);
    chk("bp_idle", 32'(res_valid), 32'(0));
    drain();

    // Round-robin with both requesters always valid.
    set_req(0, 0, 2, 3, 5, 7);
    set_req(1, 1, 2, 3, 5, 7);
    req_valid = 2'b11;
    for (int c = 0; c < 8; c++) begin
      logic [1:0] e;
      @(negedge clk);
      if (c % 2 != 0)         e = 2'b00;
      else if ((c / 2) % 2 == 0) e = 2'b01;
      else                    e = 2'b10;
      chk("rr_rdy", 32'(req_ready), 32'(e));
      if (e == 2'b01) push(1'b0, 10, 21, 1'b0);
      if (e == 2'b10) push(1'b1, 14, 15, 1'b0);
    end
    @(posedge clk); #1;
    req_valid = 2'b00;
    drain();
    drain();

    // Truncation on an 8-bit instance: 20*20 = 400 -> 144.
    v8_l_num[7:0] = 8'd20; v8_l_den[7:0] = 8'd1;
    v8_r_num[7:0] = 8'd20; v8_r_den[7:0] = 8'd1;
    v8_valid = 2'b01;
    @(negedge clk);
    chk("t8_rdy", 32'(v8_ready), 32'(2'b01));
    @(posedge clk); #1;
    v8_valid = 2'b00;
    for (int k = 0; k < 5 && !r8_valid; k++) @(negedge clk);
    chk("t8_valid", 32'(r8_valid), 32'(1));
    chk("t8_num", 32'(r8_num), 144);
    chk("t8_den", 32'(r8_den), 1);
    chk("t8_err", 32'(r8_err), 32'(0));
    chk("t8_tag", 32'(r8_tag), 32'(0));
    drain();

    // Reset during EXEC: op discarded, req0 wins afterwards.
    set_req(0, 0, 3, 4, 5, 7);
    set_req(1, 0, 1, 1, 1, 1);
    req_valid = 2'b01;
    @(negedge clk);
    chk("rx_rdy", 32'(req_ready), 32'(2'b01));
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("rx_val", 32'(res_valid), 32'(0));
    chk("rx_rdy0", 32'(req_ready), 32'(0));
    @(posedge clk); #1;
    chk("rx_hold", 32'(res_valid), 32'(0));
    req_valid = 2'b00;
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("rx_stale", 32'(res_valid), 32'(0));
    end
    @(posedge clk); #1;
    req_valid = 2'b11;
    @(negedge clk);
    chk("rx_first", 32'(req_ready), 32'(2'b01));
    push(1'b0, 15, 28, 1'b0);
    @(posedge clk); #1;
    req_valid = 2'b00;
    drain();
    drain();

    chk("sb_empty", 32'(sb.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
